// File: rtl/booth_dp.sv
// Radix-2 Booth multiplier datapath: M, guarded accumulator A, multiplier Q,
// guard bit Q-1 and iteration counter, driven by an 8-bit micro-op control word.
module booth_dp #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] inbus,
    input  logic [7:0]   c,
    output logic [W-1:0] outbus,
    output logic         q0,
    output logic         qm,
    output logic         count
);

    localparam int unsigned CW = $clog2(W);

    logic [W-1:0]  m_q, m_d;
    logic [W:0]    a_q, a_d;
    logic [W-1:0]  q_q, q_d;
    logic          qm1_q, qm1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  outbus_q, outbus_d;

    logic [W:0]    m_ext;
    logic [W:0]    a_sum;
    logic [W:0]    a_pre;
    logic          cnt_last;

    assign cnt_last = (cnt_q == CW'(W - 1));

    always_comb begin
        m_d      = m_q;
        a_d      = a_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        outbus_d = outbus_q;

        m_ext = {m_q[W-1], m_q};
        a_sum = c[3] ? (a_q - m_ext) : (a_q + m_ext);
        a_pre = c[2] ? a_sum : a_q;

        // The shift consumes the post-add accumulator, giving a fused Booth step.
        if (c[4]) begin
            a_d   = {a_pre[W], a_pre[W:1]};
            q_d   = {a_pre[0], q_q[W-1:1]};
            qm1_d = q_q[0];
        end else if (c[2]) begin
            a_d = a_pre;
        end

        if (c[1]) begin
            q_d = inbus;
        end

        if (c[5]) begin
            cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        end

        if (c[0]) begin
            m_d   = inbus;
            a_d   = '0;
            qm1_d = 1'b0;
            cnt_d = '0;
        end

        if (c[6]) begin
            outbus_d = a_q[W-1:0];
        end else if (c[7]) begin
            outbus_d = q_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q      <= '0;
            a_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            outbus_q <= '0;
        end else begin
            m_q      <= m_d;
            a_q      <= a_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            outbus_q <= outbus_d;
        end
    end

    assign outbus = outbus_q;
    assign q0     = q_q[0];
    assign qm     = qm1_q;
    assign count  = cnt_last;

endmodule

// File: doc/booth_dp.md
# booth_dp

Radix-2 Booth multiplier datapath that executes the 8-bit control word issued by the generic Booth control unit, and reports the status bits that unit branches on (`q0`, `qm`, `count`). It holds the multiplicand M, accumulator A, multiplier Q, the Booth guard bit Q₋₁ and an iteration counter. The two operands are loaded over a shared input bus. The 2W-bit signed product is read back over a shared output bus as A, then Q.

## Interface
- `W`, default 8: operand width in bits. W ≥ 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `inbus`  in  W: operand bus, sampled when c[0] or c[1] is high.
- `c`  in  8: control word, one bit per micro-operation (see Operation).
- `outbus`  out  W: registered result bus.
- `q0`  out  1: Q[0], combinational from the register.
- `qm`  out  1: Q₋₁, combinational from the register.
- `count`  out  1: high while cnt == W-1, combinational from the register.

## Operation
Registers:
- M is W bits.
- A is W+1 bits (sign guard, so that M = -2^(W-1) cannot overflow).
- Q is W bits.
- Q₋₁ is 1 bit.
- cnt is $clog2(W) bits.
- outbus is W bits.

Control bits, applied on the rising edge:
- c[0] LOAD_M: M ← inbus. Also clears A, Q₋₁ and cnt.
- c[1] LOAD_Q: Q ← inbus.
- c[2] ARITH: A ← A + sext(M), or A ← A − sext(M) when c[3] = 1. The result is taken mod 2^(W+1).
- c[3] SUB: only qualifies c[2]. It is ignored when c[2] = 0.
- c[4] SHIFT: arithmetic right shift of the concatenation {A, Q, Q₋₁} by 1. A[W] is replicated, A[0] moves to Q[W-1], and Q[0] moves to Q₋₁.
- c[5] INC: cnt ← cnt + 1. When cnt == W-1 it wraps to 0.
- c[6] OUT_A: outbus ← A[W-1:0].
- c[7] OUT_Q: outbus ← Q.

Simultaneous bits:
- c[0] overrides c[2] and c[4] for A and Q₋₁.
- c[1] overrides c[4] for Q.
- c[2] together with c[4]: the shift operates on the post-add A, i.e. a fused Booth step.
- c[6] together with c[7]: c[6] wins.
- c[0] together with c[5]: cnt ends at 0.
- Any other combination acts independently.

Holding and status:
- With c = 0, every register holds.
- outbus holds its last driven value until the next c[6] or c[7].
- The product is {A[W-1:0], Q} after W ARITH/SHIFT iterations.
- The control unit asserts c[5] in CHECK only while `count` = 0, so exactly W shifts occur before it branches to output.

## Timing
- Reset values: M = 0, A = 0, Q = 0, Q₋₁ = 0, cnt = 0, outbus = 0. Therefore `q0` = 0, `qm` = 0 and `count` = 0.
- Reset asserted mid-operation clears everything immediately, independent of clk. Control bits are ignored while rst is high.
- Latency is one cycle for every control bit: the effect is visible after the edge that closes the cycle in which the bit is high.
- `q0`, `qm` and `count` reflect register state with no added delay. A c[4] or c[5] edge updates them in the same cycle as the register change.
- outbus is valid one cycle after the c[6] or c[7] cycle, i.e. during the control unit's OUTPUT_Q and STOP states.

## Test plan
- Reset: assert rst mid-sequence with A = 0x1F3 and cnt = 5 → all outputs read 0 immediately. Apply c = 0 with rst low for 3 cycles → all outputs stay 0.
- W=8, M=3, Q=0xFC (−4): run the full CU-style sequence (8 scan/shift/check rounds) → OUT_A gives 0xFF, OUT_Q gives 0xF4, i.e. the product −12.
- M=0x80, Q=0x80 (−128 × −128) → A=0x40, Q=0x00 (16384). No overflow, because of the A guard bit.
- M=0x7F, Q=0x7F → A=0x3F, Q=0x01 (16129). Check `q0`/`qm` after each shift against the Booth recode sequence.
- Counter: c[0], then 7 cycles of c[5] → `count` rises exactly after the 7th. One more c[5] → cnt wraps to 0 and `count` falls. c[0] with c[5] → cnt = 0.
- Collisions: A=0, M=5, Q=0x01, Q₋₁=0, apply c[2]|c[3]|c[4] in one cycle → A = 0x1FD (−3, arithmetic shift of −5), Q = 0x80, Q₋₁ = 1. Apply c[6]|c[7] → outbus shows A[7:0] = 0xFD.
